// File: rtl/mips_memory.sv
// Unified instruction/data memory responder for the multicycle mips core.
// A loader fills the image in LOAD; RUN serves fetch and data ports and records faults.
module mips_memory #(
   parameter logic [31:0] BASE_ADDR  = 32'h80000000,
   parameter int          ADDR_WIDTH = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_in,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_out,
   input  logic        data_rd_wr,
   output logic [31:0] data_in,
   input  logic        load_valid,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        busy,
   output logic        err_range,
   output logic        err_align,
   output logic [31:0] err_addr
);

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
   logic [0:0]  r_state;
   logic [31:0] r_instrIn;
   logic [31:0] r_dataIn;
   logic        r_errRange;
   logic        r_errAlign;
   logic [31:0] r_errAddr;

   logic [31:0]           w_instrOff, w_dataOff, w_loadOff;
   logic                  w_instrIn, w_dataIn, w_loadIn;
   logic [ADDR_WIDTH-1:0] w_instrIdx, w_dataIdx, w_loadIdx;
   logic                  w_dataMis;
   logic                  w_memWe;
   logic [ADDR_WIDTH-1:0] w_wrIdx;
   logic [31:0]           w_wrData;
   logic                  w_setRange, w_setAlign, w_dataFault;
   logic [31:0]           w_faultAddr;

   // Offsets wrap modulo 2^32, so addresses below the base land far out of window.
   function automatic logic inWindow(input logic [31:0] off);
      return (off >> (ADDR_WIDTH + 2)) == 32'd0;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] toIndex(input logic [31:0] off);
      return ADDR_WIDTH'(off >> 2);
   endfunction

   assign w_instrOff = instr_addr - BASE_ADDR;
   assign w_dataOff  = data_addr - BASE_ADDR;
   assign w_loadOff  = load_addr - BASE_ADDR;
   assign w_instrIn  = inWindow(w_instrOff);
   assign w_dataIn   = inWindow(w_dataOff);
   assign w_loadIn   = inWindow(w_loadOff);
   assign w_instrIdx = toIndex(w_instrOff);
   assign w_dataIdx  = toIndex(w_dataOff);
   assign w_loadIdx  = toIndex(w_loadOff);
   assign w_dataMis  = data_addr[1:0] != 2'b00;

   assign busy       = (r_state == ST_LOAD);
   assign load_ready = (r_state == ST_LOAD);
   assign instr_in   = r_instrIn;
   assign data_in    = r_dataIn;
   assign err_range  = r_errRange;
   assign err_align  = r_errAlign;
   assign err_addr   = r_errAddr;

   // Single write port: the loader owns it in LOAD, the core data port in RUN.
   always_comb begin
      w_memWe  = 1'b0;
      w_wrIdx  = w_loadIdx;
      w_wrData = load_data;
      if (!reset) begin
         if (r_state == ST_LOAD) begin
            w_memWe = load_valid && w_loadIn;
         end else begin
            w_memWe  = !data_rd_wr && w_dataIn && !w_dataMis;
            w_wrIdx  = w_dataIdx;
            w_wrData = data_out;
         end
      end
   end

   // Data-port faults outrank a simultaneous fetch fault when choosing err_addr.
   always_comb begin
      w_setRange  = 1'b0;
      w_setAlign  = 1'b0;
      w_dataFault = 1'b0;
      w_faultAddr = instr_addr;
      if (r_state == ST_LOAD) begin
         w_setRange  = load_valid && !w_loadIn;
         w_faultAddr = load_addr;
      end else begin
         w_dataFault = !w_dataIn || w_dataMis;
         w_setRange  = !w_dataIn || !w_instrIn;
         w_setAlign  = w_dataMis;
         if (w_dataFault) begin
            w_faultAddr = data_addr;
         end
      end
   end

   // The array is never reset so a program image survives a core reset.
   always_ff @(posedge clk) begin
      if (w_memWe) begin
         r_mem[w_wrIdx] <= w_wrData;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_LOAD;
         r_instrIn  <= 32'd0;
         r_dataIn   <= 32'd0;
         r_errRange <= 1'b0;
         r_errAlign <= 1'b0;
         r_errAddr  <= 32'd0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_instrIn <= 32'd0;
            r_dataIn  <= 32'd0;
            if (load_valid && load_last) begin
               r_state <= ST_RUN;
            end
         end else begin
            r_instrIn <= w_instrIn ? r_mem[w_instrIdx] : 32'd0;
            if (data_rd_wr) begin
               r_dataIn <= w_dataIn ? r_mem[w_dataIdx] : 32'd0;
            end
         end
         if ((w_setRange || w_setAlign) && !r_errRange && !r_errAlign) begin
            r_errAddr <= w_faultAddr;
         end
         if (w_setRange) begin
            r_errRange <= 1'b1;
         end
         if (w_setAlign) begin
            r_errAlign <= 1'b1;
         end
      end
   end

endmodule
